// File: rtl/gsd_pkg.sv
// gray_stream_decoder shared constants and slot-mapping helpers.
// Default word width and the trailing-zero based slot decode.
package gsd_pkg;

  localparam int NBITS_DEF = 10;
  localparam logic [3:0] SLOT_IDLE = 4'hF;

  // Index of the lowest set bit; 16 when v is zero.
  function automatic logic [4:0] tz(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd16;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) n = 5'(i);
    end
    return n;
  endfunction

  function automatic logic [3:0] slot_of(
    input logic [4:0] j,
    input int         nbits
  );
    logic [3:0] s;
    s = SLOT_IDLE;
    if (j != 5'd0 && int'(j) <= nbits) begin
      s = 4'(nbits - int'(j));
    end
    return s;
  endfunction

endpackage

// File: rtl/gsd_slot_decode.sv
// Frame counter to word-bit slot decode for gray_stream_decoder.
// Odd counts and zero are idle; otherwise bit = NBITS - tz(c).
module gsd_slot_decode
  import gsd_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic [NBITS:0] c,
  output logic [3:0]     slot_idx,
  output logic           idle
);

  logic [4:0] j;

  always_comb begin
    j        = tz(16'(c));
    slot_idx = slot_of(j, NBITS);
    idle     = (slot_idx == SLOT_IDLE);
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Rebuilds one NBITS word per frame from the muxed serial stream.
// GSD_DENSITY_EN adds a per-frame ones counter on the density port.
module gray_stream_decoder
  import gsd_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk_ext,
  input  logic             rstb_ext,
  input  logic             sync_clr,
  input  logic             in_bit,
  output logic [NBITS-1:0] word_out,
  output logic             word_valid,
  output logic             word_err,
  output logic [3:0]       slot_idx,
  output logic [NBITS:0]   density
);

  localparam logic [NBITS:0] C_LAST = '1;
  localparam logic [NBITS:0] C_ONE =
    {{NBITS{1'b0}}, 1'b1};

  logic [NBITS:0]   c;
  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] seen;
  logic [NBITS-1:0] sel;
  logic             err;
  logic             idle;
  logic             frame_end;
  logic             mismatch;

  gsd_slot_decode #(
    .NBITS(NBITS)
  ) u_dec (
    .c       (c),
    .slot_idx(slot_idx),
    .idle    (idle)
  );

  always_comb begin
    sel = '0;
    for (int b = 0; b < NBITS; b++) begin
      if (!idle && slot_idx == 4'(b)) sel[b] = 1'b1;
    end
  end

  assign frame_end = (c == C_LAST);
  assign mismatch  =
    |(sel & seen & (shadow ^ {NBITS{in_bit}}));

  always_ff @(posedge clk_ext or negedge rstb_ext) begin
    if (!rstb_ext) begin
      c          <= '0;
      shadow     <= '0;
      seen       <= '0;
      err        <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_err   <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (sync_clr) begin
        c      <= '0;
        shadow <= '0;
        seen   <= '0;
        err    <= 1'b0;
      end else if (frame_end) begin
        c          <= '0;
        word_out   <= shadow;
        word_valid <= 1'b1;
        word_err   <= err | ~&seen;
        shadow     <= '0;
        seen       <= '0;
        err        <= 1'b0;
      end else begin
        c      <= c + C_ONE;
        shadow <= (shadow & ~sel) |
                  (sel & {NBITS{in_bit}});
        seen   <= seen | sel;
        if (mismatch) err <= 1'b1;
      end
    end
  end

`ifdef GSD_DENSITY_EN
  logic [NBITS:0] ones;

  always_ff @(posedge clk_ext or negedge rstb_ext) begin
    if (!rstb_ext) begin
      ones    <= '0;
      density <= '0;
    end else if (sync_clr) begin
      ones <= '0;
    end else if (frame_end) begin
      density <= ones;
      ones    <= '0;
    end else if (!idle) begin
      ones <= ones + {{NBITS{1'b0}}, in_bit};
    end
  end
`else
  assign density = '0;
`endif

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Randomized scoreboard bench for gray_stream_decoder.
// Frame model works from counter arithmetic, not the RTL decode.
module tb_gray_stream_decoder;

  localparam int NB    = 10;
  localparam int CLAST = (1 << (NB + 1)) - 1;

  logic          clk_ext  = 1'b0;
  logic          rstb_ext = 1'b1;
  logic          sync_clr = 1'b0;
  logic          in_bit   = 1'b0;
  logic [NB-1:0] word_out;
  logic          word_valid;
  logic          word_err;
  logic [3:0]    slot_idx;
  logic [NB:0]   density;

  typedef struct {
    int w;
    int e;
    int d;
    int due;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  int          mc;
  bit [NB-1:0] m_sh;
  bit [NB-1:0] m_seen;
  bit          m_err;
  int          m_ones;

  gray_stream_decoder #(
    .NBITS(NB)
  ) dut (
    .clk_ext   (clk_ext),
    .rstb_ext  (rstb_ext),
    .sync_clr  (sync_clr),
    .in_bit    (in_bit),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_err  (word_err),
    .slot_idx  (slot_idx),
    .density   (density)
  );

  always #5 clk_ext = ~clk_ext;

  always @(posedge clk_ext) cyc++;

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Bit b owns counts that are odd multiples of 2^(NB-b).
  function automatic int ref_slot(input int c);
    int v;
    int j;
    if (c == 0) return 15;
    v = c;
    j = 0;
    while (v % 2 == 0) begin
      v = v / 2;
      j++;
    end
    if (j == 0 || j > NB) return 15;
    return NB - j;
  endfunction

  task automatic model_clear();
    m_sh   = '0;
    m_seen = '0;
    m_err  = 1'b0;
    m_ones = 0;
  endtask

  // Called at a falling edge; models the rising edge that follows.
  task automatic step(input bit [NB-1:0] w,
                      input bit flip,
                      input bit clr);
    int   s;
    bit   b;
    exp_t e;
    s = ref_slot(mc);
    check("slot_idx", int'(slot_idx), s);
    if (s == 15) b = 1'($urandom);
    else         b = w[s] ^ flip;
    in_bit   = b;
    sync_clr = clr;
    if (clr) begin
      mc = 0;
      model_clear();
    end else if (mc == CLAST) begin
      e.w = int'(m_sh);
      e.e = (m_err || m_seen != '1) ? 1 : 0;
`ifdef GSD_DENSITY_EN
      e.d = m_ones;
`else
      e.d = 0;
`endif
      e.due = cyc + 1;
      q.push_back(e);
      model_clear();
      mc = 0;
    end else begin
      if (s != 15) begin
        if (m_seen[s] && m_sh[s] != b) m_err = 1'b1;
        m_sh[s]   = b;
        m_seen[s] = 1'b1;
        m_ones    = m_ones + int'(b);
      end
      mc++;
    end
    @(negedge clk_ext);
  endtask

  task automatic run(input bit [NB-1:0] w, input int n);
    for (int i = 0; i < n; i++) step(w, 1'b0, 1'b0);
  endtask

  task automatic run_until(input bit [NB-1:0] w,
                           input int target);
    for (int i = 0; i < 4096 && mc != target; i++) begin
      step(w, 1'b0, 1'b0);
    end
    check("reach_c", mc, target);
  endtask

  task automatic check_reset_outs();
    #1;
    check("rst_word_out", int'(word_out), 0);
    check("rst_word_valid", int'(word_valid), 0);
    check("rst_word_err", int'(word_err), 0);
    check("rst_density", int'(density), 0);
    check("rst_slot_idx", int'(slot_idx), 15);
  endtask

  always @(negedge clk_ext) begin
    exp_t e;
    if (mon_en) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        check("missed_valid", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (word_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("valid_cycle", cyc, e.due);
          check("word_out", int'(word_out), e.w);
          check("word_err", int'(word_err), e.e);
          check("density", int'(density), e.d);
        end
      end
    end
  end

  initial begin
    bit [NB-1:0] w;
    int          fc;
    bit          fen;

    @(negedge clk_ext);
    rstb_ext = 1'b0;
    check_reset_outs();
    @(negedge clk_ext);
    mc = 0;
    model_clear();
    rstb_ext = 1'b1;
    mon_en   = 1'b1;

    run(10'h2A5, 4096);
    run(10'h3FF, 2048);
    run(10'h000, 2048);

    run_until(10'h100, 600);
    run_until(10'h080, 0);
    run(10'h080, 2048);

    for (int k = 0; k < 3; k++) begin
      w   = NB'($urandom);
      fen = 1'($urandom);
      fc  = $urandom_range(0, CLAST);
      for (int i = 0; i <= CLAST; i++) begin
        step(w, fen && (i == fc), 1'b0);
      end
    end

    run_until(10'h155, 1500);
    step(10'h155, 1'b0, 1'b1);
    run(10'h155, 2048);

    run_until(10'h2C3, 900);
    rstb_ext = 1'b0;
    check_reset_outs();
    mc = 0;
    model_clear();
    @(negedge clk_ext);
    rstb_ext = 1'b1;
    run(10'h2C3, 2048);

    @(negedge clk_ext);
    @(negedge clk_ext);
    check("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
